// File: rtl/counter_arb_pkg.sv
// Shared types and default sizing for the counter arbiter.
// Holds the FSM state encoding and a helper that sizes owner index fields.
package counter_arb_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_CNT_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/counter_arb_rr_pick.sv
// Combinational round-robin picker: the first requester strictly after
// last_idx, scanning upward and wrapping from NUM_REQ-1 back to 0.
module rr_pick
  import counter_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_idx,
  output logic [NUM_REQ-1:0] pick_oh,
  output logic [IDX_W-1:0]   pick_idx
);

  logic found;

  always_comb begin
    pick_oh  = '0;
    pick_idx = '0;
    found    = 1'b0;
    // Offset 1 is the highest priority, offset NUM_REQ (last_idx itself) the lowest.
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!found && req[(int'(last_idx) + i) % NUM_REQ]) begin
        pick_idx = IDX_W'((int'(last_idx) + i) % NUM_REQ);
        pick_oh[(int'(last_idx) + i) % NUM_REQ] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_arb.sv
// Arbitrates one shared loadable counter among NUM_REQ requesters: each
// session loads the owner's value and runs until terminal count or abort.
module counter_arb
  import counter_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] req_val,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic [NUM_REQ-1:0]       abort,
  output logic                     busy,
  output logic                     cnt_load,
  output logic [CNT_W-1:0]         cnt_din,
  input  logic [CNT_W-1:0]         cnt_dout
);

  localparam int                IDX_W    = idx_w(NUM_REQ);
  localparam logic [IDX_W-1:0]  LAST_RST = IDX_W'(NUM_REQ - 1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [NUM_REQ-1:0]   abort_q, abort_d;
  logic                 busy_q, busy_d;
  logic                 cnt_load_q, cnt_load_d;
  logic [CNT_W-1:0]     cnt_din_q, cnt_din_d;

  logic [NUM_REQ-1:0]   pick_oh;
  logic [IDX_W-1:0]     pick_idx;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req      (req),
    .last_idx (last_q),
    .pick_oh  (pick_oh),
    .pick_idx (pick_idx)
  );

  // Outputs are computed one state ahead and registered, so each pulse
  // lines up with the state it belongs to and req never reaches cnt_load
  // combinationally.
  always_comb begin
    // NOTE: every _d signal gets a default first; a path that leaves one
    // unassigned would infer a latch.
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    gnt_d      = '0;
    done_d     = '0;
    abort_d    = '0;
    cnt_load_d = 1'b0;
    cnt_din_d  = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d    = ST_LOAD;
          owner_d    = pick_idx;
          gnt_d      = pick_oh;
          cnt_load_d = 1'b1;
          cnt_din_d  = req_val[pick_idx*CNT_W +: CNT_W];
        end
      end
      ST_LOAD: state_d = ST_RUN;
      ST_RUN: begin
        // A dropped request wins over a simultaneous terminal count.
        if (!req[owner_q]) begin
          state_d          = ST_DONE;
          abort_d[owner_q] = 1'b1;
        end else if (cnt_dout == '1) begin
          state_d         = ST_DONE;
          done_d[owner_q] = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        last_d  = owner_q;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      last_q     <= LAST_RST;
      gnt_q      <= '0;
      done_q     <= '0;
      abort_q    <= '0;
      busy_q     <= 1'b0;
      cnt_load_q <= 1'b0;
      cnt_din_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
      busy_q     <= busy_d;
      cnt_load_q <= cnt_load_d;
      cnt_din_q  <= cnt_din_d;
    end
  end

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign abort    = abort_q;
  assign busy     = busy_q;
  assign cnt_load = cnt_load_q;
  assign cnt_din  = cnt_din_q;

endmodule

// File: tb/tb_counter_arb.sv
// Self-checking bench for counter_arb: directed session table, reset corner
// cases, then random sessions checked against a session-level model.
module tb_counter_arb;

  localparam int NR = 4;
  localparam int CW = 4;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [NR-1:0]  req = '0;
  logic [NR*CW-1:0] req_val = '0;
  logic [NR-1:0]  gnt, done, abort;
  logic           busy, cnt_load;
  logic [CW-1:0]  cnt_din, cnt_dout;

  counter_arb #(.NUM_REQ(NR), .CNT_W(CW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .req_val  (req_val),
    .gnt      (gnt),
    .done     (done),
    .abort    (abort),
    .busy     (busy),
    .cnt_load (cnt_load),
    .cnt_din  (cnt_din),
    .cnt_dout (cnt_dout)
  );

  always #5 clk = ~clk;

  // Shared loadable counter, reset active-high from ~reset_n.
  logic          cnt_rst;
  logic [CW-1:0] cnt_q;
  assign cnt_rst  = ~reset_n;
  assign cnt_dout = cnt_q;
  always @(posedge clk or posedge cnt_rst) begin
    if (cnt_rst)       cnt_q <= '0;
    else if (cnt_load) cnt_q <= cnt_din;
    else               cnt_q <= cnt_q + 1'b1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;
  int last_owner = NR - 1;
  int last_pulse_cyc = 0;

  typedef struct {
    bit              rst;
    bit              apply;
    logic [NR-1:0]   req;
    logic [NR*CW-1:0] vals;
    int              drop_k;
    int              exp_owner;
    bit              exp_abort;
    int              exp_lat;
    bit              chk_gap;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // Session-level reference: owner is the first requester after the last
  // owner; a session ends at terminal count (17-V cycles after gnt) unless
  // the owner's request is seen low in RUN cycle drop_k first (ties abort).
  function automatic void predict(input logic [NR-1:0] r, input logic [NR*CW-1:0] v,
                                  input int last, input int drop_k,
                                  output int owner, output bit ab, output int lat);
    int k_done;
    owner = -1;
    for (int i = 1; i <= NR; i++)
      if (owner < 0 && r[(last + i) % NR]) owner = (last + i) % NR;
    k_done = (1 << CW) - int'(v[owner*CW +: CW]);
    if (drop_k != 0 && drop_k <= k_done) begin
      ab  = 1'b1;
      lat = drop_k + 1;
    end else begin
      ab  = 1'b0;
      lat = k_done + 1;
    end
  endfunction

  // Waits for a grant, runs one session, checks it, and returns at the
  // negedge of the IDLE cycle that follows the done/abort pulse.
  task automatic run_session(input int drop_k, input int exp_owner, input bit exp_abort,
                             input int exp_lat, input bit chk_gap);
    logic [NR*CW-1:0] saved;
    logic [CW-1:0]    v;
    logic [NR-1:0]    oh;
    bit               seen;
    int               gcyc;
    int               lat;
    saved = req_val;
    v     = saved[exp_owner*CW +: CW];
    oh    = NR'(1) << exp_owner;
    seen  = 1'b0;
    for (int w = 0; w < 8 && !seen; w++) begin
      @(negedge clk);
      if (|gnt) seen = 1'b1;
    end
    if (!seen) begin
      check("gnt_timeout", 32'd0, 32'd1);
      return;
    end
    gcyc = cyc;
    check("gnt", gnt, oh);
    check("load", {cnt_load, cnt_din}, {1'b1, v});
    if (chk_gap) check("idle_gap", gcyc - last_pulse_cyc, 2);
    req_val = $urandom;
    lat = 0;
    for (int j = 1; j <= 40 && lat == 0; j++) begin
      @(posedge clk);
      #1;
      if (j == drop_k) req[exp_owner] = 1'b0;
      @(negedge clk);
      if (j == 1) begin
        check("cnt_dout_first", cnt_dout, v);
        check("run_outs", {busy, cnt_load, cnt_din, gnt}, {1'b1, 1'b0, 4'h0, 4'h0});
      end
      if ((done | abort) != '0) lat = j;
    end
    check("latency", lat, exp_lat);
    check("done", done, exp_abort ? '0 : oh);
    check("abort", abort, exp_abort ? oh : '0);
    last_pulse_cyc = cyc;
    last_owner     = exp_owner;
    req[exp_owner] = 1'b0;
    req_val        = saved;
    @(negedge clk);
    check("busy_low", {busy, done, abort}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    req     = '0;
    repeat (2) @(negedge clk);
    reset_n    = 1'b1;
    last_owner = NR - 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int o, l, d;
    bit ab;
    logic [NR-1:0] seen_pulse;

    //          rst apply req      vals      drop own abt lat gap
    tbl[0] = '{1'b0, 1'b1, 4'b0001, 16'h000A, 0, 0, 1'b0,  7, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 4'b1111, 16'hBCDE, 0, 0, 1'b0,  3, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 4'b0000, 16'h0000, 0, 1, 1'b0,  4, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 4'b0000, 16'h0000, 0, 2, 1'b0,  5, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 4'b0000, 16'h0000, 0, 3, 1'b0,  6, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 4'b0100, 16'h0800, 5, 2, 1'b1,  6, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 4'b0010, 16'h00F0, 0, 1, 1'b0,  2, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 4'b1001, 16'h0005, 0, 3, 1'b0, 17, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 4'b0000, 16'h0000, 0, 0, 1'b0, 12, 1'b1};
    tbl[9] = '{1'b0, 1'b1, 4'b0010, 16'h00E0, 2, 1, 1'b1,  3, 1'b0};

    // Reset state, then idle with no requests.
    req = 4'b1111;
    repeat (3) @(negedge clk);
    check("reset_outs", {gnt, done, abort, busy, cnt_load, cnt_din}, 32'd0);
    req = '0;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_no_req", {gnt, busy, cnt_load}, 32'd0);

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].rst) do_reset();
      if (tbl[i].apply) begin
        req     = tbl[i].req;
        req_val = tbl[i].vals;
      end
      run_session(tbl[i].drop_k, tbl[i].exp_owner, tbl[i].exp_abort,
                  tbl[i].exp_lat, tbl[i].chk_gap);
    end

    // Reset in the middle of a RUN discards the session.
    req     = 4'b1000;
    req_val = 16'h1000;
    repeat (4) @(negedge clk);
    check("mid_run_busy", busy, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_run_reset_outs", {gnt, done, abort, busy, cnt_load, cnt_din}, 32'd0);
    req     = 4'b1001;
    req_val = 16'h000F;
    seen_pulse = '0;
    repeat (3) begin
      @(negedge clk);
      seen_pulse = seen_pulse | done | abort | gnt;
    end
    check("reset_hold_quiet", seen_pulse, 32'd0);
    reset_n    = 1'b1;
    last_owner = NR - 1;
    run_session(0, 0, 1'b0, 2, 1'b0);
    run_session(0, 3, 1'b0, 17, 1'b1);

    // Random sessions against the reference model.
    for (int n = 0; n < 40; n++) begin
      req     = NR'($urandom_range(1, (1 << NR) - 1));
      req_val = $urandom;
      d       = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 17)) : 0;
      predict(req, req_val, last_owner, d, o, ab, l);
      run_session(d, o, ab, l, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
